// File: rtl/axis_bitop_pkg.sv
// Shared types and the per-beat transform for the axis_bitop stream stage.
package axis_bitop_pkg;

    localparam int MAX_W = 512;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_XOR  = 2'd2,
        MODE_REV  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

    // Operands are zero-extended to MAX_W; reversal mirrors only the low 'width' bits.
    function automatic logic [MAX_W-1:0] bitop_apply(
        input mode_e             mode,
        input logic [MAX_W-1:0]  mask,
        input logic [MAX_W-1:0]  data,
        input int                width
    );
        logic [MAX_W-1:0] res;
        res = data;
        case (mode)
            MODE_PASS: res = data;
            MODE_INV:  res = ~data;
            MODE_XOR:  res = data ^ mask;
            MODE_REV: begin
                res = '0;
                for (int i = 0; i < MAX_W; i++) begin
                    if (i < width) res[width-1-i] = data[i];
                end
            end
            default:   res = data;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Registered valid/ready skid buffer: full throughput, no combinational ready path.
module axis_skid_buf
    import axis_bitop_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    skid_state_e r_state;
    skid_state_e w_next;
    logic        r_ready;
    logic [W-1:0] r_out;
    logic [W-1:0] r_skid;
    logic        w_accept;
    logic        w_load_out;
    logic        w_load_skid;
    logic        w_out_from_skid;

    assign w_accept = i_valid && r_ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_next          = r_state;
        w_load_out      = 1'b0;
        w_load_skid     = 1'b0;
        w_out_from_skid = 1'b0;
        case (r_state)
            SKID_EMPTY: begin
                if (w_accept) begin
                    w_next     = SKID_ONE;
                    w_load_out = 1'b1;
                end
            end
            SKID_ONE: begin
                if (w_accept && i_ready) begin
                    w_load_out = 1'b1;
                end else if (w_accept) begin
                    w_next      = SKID_FULL;
                    w_load_skid = 1'b1;
                end else if (i_ready) begin
                    w_next = SKID_EMPTY;
                end
            end
            SKID_FULL: begin
                if (i_ready) begin
                    w_next          = SKID_ONE;
                    w_out_from_skid = 1'b1;
                end
            end
            default: w_next = SKID_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SKID_EMPTY;
            r_ready <= 1'b0;
            // NOTE: payload registers are reset too, so the outputs read 0 while rst is high.
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            r_state <= w_next;
            r_ready <= (w_next != SKID_FULL);
            if (w_load_out) begin
                r_out <= i_data;
            end else if (w_out_from_skid) begin
                r_out <= r_skid;
            end
            if (w_load_skid) r_skid <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_valid = (r_state != SKID_EMPTY);
    assign o_data  = r_out;

endmodule

// File: rtl/axis_bitop.sv
// AXI4-Stream bit-manipulation stage: per-packet transform select, registered output, beat/packet counters.
module axis_bitop
    import axis_bitop_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int KEEP_W = DATA_W / 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode_i,
    input  logic [DATA_W-1:0] mask_i,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic [KEEP_W-1:0] s_axis_tkeep,
    input  logic              s_axis_tlast,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic [KEEP_W-1:0] m_axis_tkeep,
    output logic              m_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [CNT_W-1:0]  pkt_count_o,
    output logic [CNT_W-1:0]  beat_count_o,
    output logic              in_pkt_o
);

    localparam int PAY_W = DATA_W + KEEP_W + 1;

    logic              w_s_ready;
    logic              w_accept;
    logic              w_m_hs;
    logic              r_in_pkt;
    mode_e             r_mode;
    logic [DATA_W-1:0] r_mask;
    mode_e             w_mode;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_xf;
    logic [PAY_W-1:0]  w_m_payload;
    logic [CNT_W-1:0]  r_pkt_cnt;
    logic [CNT_W-1:0]  r_beat_cnt;

    assign w_accept = s_axis_tvalid && w_s_ready;
    assign w_m_hs   = m_axis_tvalid && m_axis_tready;

    // The first beat of a packet uses the live inputs; later beats use the latched copy.
    assign w_mode = r_in_pkt ? r_mode : mode_e'(mode_i);
    assign w_mask = r_in_pkt ? r_mask : mask_i;
    assign w_xf   = DATA_W'(bitop_apply(w_mode, MAX_W'(w_mask), MAX_W'(s_axis_tdata), DATA_W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_pkt <= 1'b0;
            r_mode   <= MODE_PASS;
            r_mask   <= '0;
        end else if (w_accept) begin
            if (!r_in_pkt) begin
                r_mode   <= mode_e'(mode_i);
                r_mask   <= mask_i;
                r_in_pkt <= !s_axis_tlast;
            end else if (s_axis_tlast) begin
                r_in_pkt <= 1'b0;
            end
        end
    end

    axis_skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (s_axis_tvalid),
        .o_ready (w_s_ready),
        .i_data  ({w_xf, s_axis_tkeep, s_axis_tlast}),
        .o_valid (m_axis_tvalid),
        .o_data  (w_m_payload),
        .i_ready (m_axis_tready)
    );

    assign m_axis_tdata = w_m_payload[PAY_W-1 -: DATA_W];
    assign m_axis_tkeep = w_m_payload[KEEP_W:1];
    assign m_axis_tlast = w_m_payload[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pkt_cnt  <= '0;
            r_beat_cnt <= '0;
        end else if (w_m_hs) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (m_axis_tlast) r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
        end
    end

    assign s_axis_tready = w_s_ready;
    assign pkt_count_o   = r_pkt_cnt;
    assign beat_count_o  = r_beat_cnt;
    assign in_pkt_o      = r_in_pkt;

endmodule

// File: tb/tb_axis_bitop.sv
// Scoreboard bench for axis_bitop: 32-bit instance for function/handshake, 64-bit/CNT_W=4 instance for width and wrap.
module tb_axis_bitop;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } beat_t;

    logic        clk;
    logic        rst;
    logic [1:0]  mode_i;
    logic [31:0] mask_i;
    logic [31:0] s_tdata;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tlast;
    logic        m_tvalid;
    logic        m_tready;
    logic [31:0] pkt_cnt;
    logic [31:0] beat_cnt;
    logic        in_pkt;

    logic [1:0]  d2_mode;
    logic [63:0] d2_mask;
    logic [63:0] d2_s_tdata;
    logic [7:0]  d2_s_tkeep;
    logic        d2_s_tlast;
    logic        d2_s_tvalid;
    logic        d2_s_tready;
    logic [63:0] d2_m_tdata;
    logic [7:0]  d2_m_tkeep;
    logic        d2_m_tlast;
    logic        d2_m_tvalid;
    logic        d2_m_tready;
    logic [3:0]  d2_pkt_cnt;
    logic [3:0]  d2_beat_cnt;
    logic        d2_in_pkt;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int acc_cnt  = 0;

    beat_t exp_q[$];
    beat_t got_q[$];

    logic        tb_in_pkt = 1'b0;
    logic [1:0]  tb_mode   = 2'd0;
    logic [31:0] tb_mask   = '0;

    axis_bitop #(.DATA_W(32), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .mode_i        (mode_i),
        .mask_i        (mask_i),
        .s_axis_tdata  (s_tdata),
        .s_axis_tkeep  (s_tkeep),
        .s_axis_tlast  (s_tlast),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tlast  (m_tlast),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .pkt_count_o   (pkt_cnt),
        .beat_count_o  (beat_cnt),
        .in_pkt_o      (in_pkt)
    );

    axis_bitop #(.DATA_W(64), .CNT_W(4)) dut64 (
        .clk           (clk),
        .rst           (rst),
        .mode_i        (d2_mode),
        .mask_i        (d2_mask),
        .s_axis_tdata  (d2_s_tdata),
        .s_axis_tkeep  (d2_s_tkeep),
        .s_axis_tlast  (d2_s_tlast),
        .s_axis_tvalid (d2_s_tvalid),
        .s_axis_tready (d2_s_tready),
        .m_axis_tdata  (d2_m_tdata),
        .m_axis_tkeep  (d2_m_tkeep),
        .m_axis_tlast  (d2_m_tlast),
        .m_axis_tvalid (d2_m_tvalid),
        .m_axis_tready (d2_m_tready),
        .pkt_count_o   (d2_pkt_cnt),
        .beat_count_o  (d2_beat_cnt),
        .in_pkt_o      (d2_in_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change #1 after posedge, so the negedge sees what the next posedge will see.
    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) got_q.push_back('{data: m_tdata, keep: m_tkeep, last: m_tlast});
        if (!rst && s_tvalid && s_tready) acc_cnt++;
    end

    function automatic logic [31:0] model(input logic [1:0] m, input logic [31:0] mk, input logic [31:0] d);
        logic [31:0] r;
        case (m)
            2'd0:    r = d;
            2'd1:    r = ~d;
            2'd2:    r = d ^ mk;
            default: r = {<<{d}};
        endcase
        return r;
    endfunction

    task automatic send_beat(input logic [31:0] d, input logic last, input logic [1:0] m,
                             input logic [31:0] mk, input logic [3:0] keep);
        int n;
        logic [1:0]  eff_m;
        logic [31:0] eff_mk;
        s_tdata  = d;
        s_tlast  = last;
        mode_i   = m;
        mask_i   = mk;
        s_tkeep  = keep;
        s_tvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_tready) begin
            chk_cnt++;
            $display("FAIL send_timeout: s_axis_tready=%b required 1 for beat %h", s_tready, d);
        end else begin
            if (!tb_in_pkt) begin
                tb_mode   = m;
                tb_mask   = mk;
                tb_in_pkt = !last;
            end else if (last) begin
                tb_in_pkt = 1'b0;
            end
            eff_m  = tb_mode;
            eff_mk = tb_mask;
            exp_q.push_back('{data: model(eff_m, eff_mk, d), keep: keep, last: last});
        end
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        beat_t e;
        beat_t g;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++;
        if (got_q.size() !== exp_q.size())
            $display("FAIL %s_count: got %0d beats, required %0d", name, got_q.size(), exp_q.size());
        else
            pass_cnt++;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            chk_cnt++;
            if (g !== e)
                $display("FAIL %s_beat: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                         name, g.data, g.keep, g.last, e.data, e.keep, e.last);
            else
                pass_cnt++;
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic check_counts(input string name, input logic [31:0] pk, input logic [31:0] bt);
        chk_cnt++;
        if (pkt_cnt !== pk || beat_cnt !== bt)
            $display("FAIL %s_counters: pkt=%0d beat=%0d, required pkt=%0d beat=%0d", name, pkt_cnt, beat_cnt, pk, bt);
        else
            pass_cnt++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        chk_cnt++;
        if ({m_tvalid, s_tready, in_pkt} !== 3'b000 || pkt_cnt !== 0 || beat_cnt !== 0 || m_tdata !== 0)
            $display("FAIL reset_state: m_tvalid=%b s_tready=%b in_pkt=%b pkt=%0d beat=%0d data=%h, required all 0",
                     m_tvalid, s_tready, in_pkt, pkt_cnt, beat_cnt, m_tdata);
        else
            pass_cnt++;
        rst = 1'b0;
        #1;
        chk_cnt++;
        if (s_tready !== 1'b0) $display("FAIL reset_ready_early: s_tready=%b required 0", s_tready);
        else pass_cnt++;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (s_tready !== 1'b1) $display("FAIL reset_ready_rise: s_tready=%b required 1", s_tready);
        else pass_cnt++;
    endtask

    task automatic test_single_invert();
        send_beat(32'hFF00FF00, 1'b1, 2'd1, 32'h0, 4'hF);
        chk_cnt++;
        if (m_tvalid !== 1'b1 || m_tdata !== 32'h00FF00FF)
            $display("FAIL invert_latency: m_tvalid=%b data=%h, required 1 and 00ff00ff", m_tvalid, m_tdata);
        else
            pass_cnt++;
        drain("invert");
        check_counts("invert", 32'd1, 32'd1);
    endtask

    task automatic test_modes();
        send_beat(32'h12345678, 1'b1, 2'd2, 32'h0000FFFF, 4'hF);
        send_beat(32'h00000001, 1'b1, 2'd3, 32'h0, 4'h3);
        for (int i = 0; i < 8; i++) send_beat(32'(i), i == 7, 2'd0, 32'h0, 4'hF);
        drain("modes");
        check_counts("modes", 32'd4, 32'd11);
    endtask

    task automatic test_mid_packet_mode();
        for (int i = 0; i < 8; i++) begin
            send_beat(32'(i), i == 7, (i >= 3) ? 2'd0 : 2'd1, 32'h0, 4'hF);
            if (i == 0) begin
                chk_cnt++;
                if (in_pkt !== 1'b1) $display("FAIL in_pkt_high: in_pkt=%b required 1", in_pkt);
                else pass_cnt++;
            end
        end
        chk_cnt++;
        if (in_pkt !== 1'b0) $display("FAIL in_pkt_low: in_pkt=%b required 0", in_pkt);
        else pass_cnt++;
        send_beat(32'h100, 1'b0, 2'd0, 32'h0, 4'hF);
        send_beat(32'h101, 1'b1, 2'd1, 32'h0, 4'hF);
        drain("mid_mode");
        check_counts("mid_mode", 32'd6, 32'd21);
    endtask

    task automatic test_back_to_back();
        int a0;
        logic [31:0] held;
        m_tready = 1'b0;
        a0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) send_beat(32'hA0 + 32'(i), i == 5, 2'd0, 32'h0, 4'hF);
            end
            begin
                @(negedge clk);
                @(negedge clk);
                held = m_tdata;
                repeat (3) begin
                    @(negedge clk);
                    chk_cnt++;
                    if (m_tvalid !== 1'b1 || m_tdata !== held)
                        $display("FAIL stall_stable: m_tvalid=%b data=%h, required 1 and %h", m_tvalid, m_tdata, held);
                    else
                        pass_cnt++;
                end
                @(posedge clk);
                #2;
                chk_cnt++;
                if (acc_cnt - a0 !== 2 || s_tready !== 1'b0 || held !== 32'hA0)
                    $display("FAIL stall_accept: accepted=%0d s_tready=%b head=%h, required 2, 0, a0",
                             acc_cnt - a0, s_tready, held);
                else
                    pass_cnt++;
                m_tready = 1'b1;
            end
        join
        drain("backpressure");
        check_counts("backpressure", 32'd7, 32'd27);
    endtask

    task automatic test_reset_mid_packet();
        for (int i = 0; i < 5; i++) send_beat(32'(i), 1'b0, 2'd2, 32'hF0F0F0F0, 4'hF);
        drain("pre_reset");
        m_tready = 1'b0;
        send_beat(32'h5, 1'b0, 2'd2, 32'hF0F0F0F0, 4'hF);
        #3;
        rst = 1'b1;
        #1;
        chk_cnt++;
        if ({m_tvalid, s_tready, in_pkt} !== 3'b000 || pkt_cnt !== 0 || beat_cnt !== 0 || m_tdata !== 0)
            $display("FAIL async_reset: m_tvalid=%b s_tready=%b in_pkt=%b pkt=%0d beat=%0d data=%h, required all 0",
                     m_tvalid, s_tready, in_pkt, pkt_cnt, beat_cnt, m_tdata);
        else
            pass_cnt++;
        exp_q.delete();
        got_q.delete();
        tb_in_pkt = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_tready = 1'b1;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (s_tready !== 1'b1) $display("FAIL post_reset_ready: s_tready=%b required 1", s_tready);
        else pass_cnt++;
        send_beat(32'h00000001, 1'b1, 2'd3, 32'h0, 4'hF);
        drain("post_reset");
        check_counts("post_reset", 32'd1, 32'd1);
    endtask

    task automatic test_wide_and_wrap();
        int n;
        for (int i = 0; i < 18; i++) begin
            d2_s_tdata  = (i == 17) ? 64'h1 : 64'(i);
            d2_mode     = (i == 17) ? 2'd3 : 2'd0;
            d2_s_tkeep  = (i == 17) ? 8'h0F : 8'hFF;
            d2_s_tlast  = 1'b1;
            d2_s_tvalid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!d2_s_tready && n < 50) begin
                n++;
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            if (i == 16) begin
                d2_s_tvalid = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                chk_cnt++;
                if (d2_pkt_cnt !== 4'd1 || d2_beat_cnt !== 4'd1)
                    $display("FAIL wrap: pkt=%0d beat=%0d, required 1 and 1", d2_pkt_cnt, d2_beat_cnt);
                else
                    pass_cnt++;
            end
        end
        chk_cnt++;
        if (d2_m_tvalid !== 1'b1 || d2_m_tdata !== 64'h8000000000000000 || d2_m_tkeep !== 8'h0F || d2_m_tlast !== 1'b1)
            $display("FAIL wide_reverse: valid=%b data=%h keep=%h last=%b, required 1 8000000000000000 0f 1",
                     d2_m_tvalid, d2_m_tdata, d2_m_tkeep, d2_m_tlast);
        else
            pass_cnt++;
        d2_s_tvalid = 1'b0;
        @(posedge clk);
        #1;
        chk_cnt++;
        if (d2_pkt_cnt !== 4'd2) $display("FAIL wide_pkt: pkt=%0d required 2", d2_pkt_cnt);
        else pass_cnt++;
    endtask

    initial begin
        rst         = 1'b1;
        mode_i      = 2'd0;
        mask_i      = '0;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tlast     = 1'b0;
        s_tvalid    = 1'b0;
        m_tready    = 1'b1;
        d2_mode     = 2'd0;
        d2_mask     = '0;
        d2_s_tdata  = '0;
        d2_s_tkeep  = '0;
        d2_s_tlast  = 1'b0;
        d2_s_tvalid = 1'b0;
        d2_m_tready = 1'b1;

        test_reset();
        test_single_invert();
        test_modes();
        test_mid_packet_mode();
        test_back_to_back();
        test_reset_mid_packet();
        test_wide_and_wrap();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axis_bitop.md
Name: axis_bitop

Overview:
Parametrised AXI4-Stream bit-manipulation stage and successor to the fixed 32-bit inverter. It applies one of four per-packet transforms to each beat: pass, invert, XOR-with-mask or bit-reverse. The output is fully registered through a skid buffer, so it sustains one beat per cycle under backpressure. It sits between the AXI4-Stream master VIP and the slave VIP in the block design, and replaces the fixed bitflip stage.

Parameters:
DATA_W, 32, tdata width in bits; multiple of 8, range 8..512
KEEP_W, DATA_W/8, tkeep width (derived; not to be overridden)
CNT_W, 32, width of the packet and beat counters

Ports:
clk  in  1  single clock; all logic on the rising edge
rst  in  1  asynchronous, active-high reset
mode_i  in  2  transform select: 0 pass, 1 invert, 2 xor mask, 3 bit-reverse
mask_i  in  DATA_W  XOR mask used in mode 2
s_axis_tdata  in  DATA_W  input data
s_axis_tkeep  in  KEEP_W  input byte enables
s_axis_tlast  in  1  input end of packet
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_tdata  out  DATA_W  transformed data
m_axis_tkeep  out  KEEP_W  passed through unchanged
m_axis_tlast  out  1  passed through unchanged
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
pkt_count_o  out  CNT_W  packets emitted (beats with tlast accepted on m_axis)
beat_count_o  out  CNT_W  beats emitted
in_pkt_o  out  1  high between the first accepted beat and the accepted tlast beat on s_axis

Behaviour:
- Reset (asynchronous assert, synchronous-safe release). All outputs are 0 while rst is high: m_axis_tvalid, s_axis_tready, counters, in_pkt_o, the skid register and the latched mode/mask.
  - s_axis_tready is registered; it rises on the first clk edge after rst deasserts.
- Transforms, applied to the full DATA_W regardless of tkeep:
  - mode 0: d
  - mode 1: ~d
  - mode 2: d ^ mask
  - mode 3: bit i goes to position DATA_W-1-i (whole-word reverse)
- Mode/mask latching:
  - mode_i and mask_i are sampled on the accepted s_axis beat with in_pkt_o low (first beat of a packet). That beat uses the sampled values directly.
  - The sampled values are held for all later beats until the tlast beat is accepted.
  - Changes to mode_i/mask_i mid-packet have no effect.
  - A single-beat packet (first beat has tlast) samples and releases in the same cycle.
- Pipeline: one output register plus one skid register.
  - Latency from s_axis handshake to m_axis_tvalid is 1 cycle.
  - Throughput is 1 beat/cycle while m_axis_tready is high.
- Handshake:
  - An s_axis beat is accepted when s_axis_tvalid && s_axis_tready.
  - m_axis data, keep and last are held stable while tvalid && !tready.
  - m_axis_tvalid never drops without a handshake.
- Skid buffer states:
  - EMPTY: output register invalid. Accept -> load output register -> ONE.
  - ONE: output valid, skid empty.
    - Accept with m_tready: reload the output register, stay in ONE.
    - Accept without m_tready: load skid -> FULL.
    - No accept with m_tready: -> EMPTY.
  - FULL: both valid, s_axis_tready=0.
    - m_tready: skid moves to the output register -> ONE, and s_axis_tready returns the next cycle.
- s_axis_tready = !(state==FULL), registered.
  - No combinational path from m_axis_tready to s_axis_tready.
- Counters:
  - beat_count_o increments on each m_axis handshake.
  - pkt_count_o increments on each m_axis handshake with tlast.
  - Both wrap at 2^CNT_W to 0.
- Reset mid-packet: in-flight beats are discarded, counters clear and in_pkt_o clears. The next accepted beat is treated as a packet start.

Decomposition:
- Package axis_bitop_pkg:
  - typedef enum mode_e {MODE_PASS=0, MODE_INV=1, MODE_XOR=2, MODE_REV=3}.
  - Skid state enum {SKID_EMPTY, SKID_ONE, SKID_FULL}.
  - Pure function bitop_apply(mode, mask, data).
- One sub-module: axis_skid_buf (parametrised on payload width DATA_W+KEEP_W+1).
  - It owns the valid/ready state machine.
  - The top holds mode/mask latching, the transform and the counters.

Test Plan:
- Mode 1, single beat 0xFF00FF00 with tlast, no backpressure -> 0x00FF00FF appears 1 cycle after accept; pkt_count_o=1, beat_count_o=1.
- Mode 2, mask 0x0000FFFF, beat 0x12345678 -> 0x1234A987; mode 3, beat 0x00000001 -> 0x80000000; mode 0, 0..7 -> identical values.
- Mode 1, 8-beat packet 0..7, then mode_i switched to 0 at beat 3:
  - all 8 outputs are inverted (0xFFFFFFFF..0xFFFFFFF8) and tlast appears only on beat 8;
  - the next packet is pass-through.
- Continuous s_axis_tvalid, m_axis_tready held low for 4 cycles:
  - exactly 2 beats are accepted, then s_axis_tready=0;
  - on release, all beats come out in order with no loss or duplication and data stays stable while stalled.
- Assert rst for 2 cycles mid-packet at beat 5 -> outputs and counters are 0 asynchronously; s_axis_tready=1 one cycle after release; a fresh packet latches the new mode.
- CNT_W=4, 17 single-beat packets -> pkt_count_o reads 1 after wrap; DATA_W=64, mode 3, 0x1 -> 0x8000000000000000, tkeep 0x0F passed through.
